pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard and flush scheduler for the 5-stage RV32 pipeline (IF, Dec, Exec, Mem, WB). It keeps its own scoreboard of in-flight destination registers for Exec, Mem and WB. From that it decides, every cycle, whether to hold IF/Dec, insert a bubble into Exec, or squash wrong-path instructions after a taken branch/jump resolves in Mem. When forwarding is compiled in, it also drives operand-bypass selects for the decode-to-Exec operand registers.

## Interface
- No parameters.
- `clk` in 1: pipeline clock, all state on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `dec_valid` in 1: Dec holds a real instruction (not a bubble).
- `dec_rs1`, `dec_rs2` in 5: source register indices of the Dec instruction.
- `dec_rs1_used`, `dec_rs2_used` in 1: the instruction actually reads that source.
- `dec_rd` in 5: destination index of the Dec instruction.
- `dec_wen` in 1: Dec instruction writes the register file.
- `dec_is_load` in 1: Dec instruction is a load (writeback from data memory).
- `redirect` in 1: taken branch/jump resolved in Mem (the fetch `npc_control`).
- `stall_if` out 1: hold PC and the IF/Dec register.
- `stall_dec` out 1: hold Dec contents; identical to `stall_if`.
- `bubble_exec` out 1: load a NOP into the Dec/Exec register (clear `wrEn`, `mem_wEn`, `branch_op`).
- `flush_dec` out 1: replace the IF/Dec register with a NOP at the next edge.
- `flush_exec` out 1: replace the Dec/Exec register with a NOP at the next edge.
- `fwd_a_sel`, `fwd_b_sel` out 2: operand bypass select. Present only with `HAZARD_FWD_EN`.
- `state` out 2: FSM state, for debug (RUN=0, STALL=1, FLUSH=2).

## Operation
- Scoreboard: three entries, Exec, Mem and WB. Each entry holds {valid, rd, wen, is_load}.
  - Each edge, WB takes Mem and Mem takes Exec.
  - Exec takes the Dec fields when `dec_valid` is high and there is no bubble or flush. Otherwise Exec becomes invalid.
- An entry matches a source when all of these hold: entry valid, wen=1, rd≠0, rd equals the source index, and the corresponding `*_used` bit is 1. x0 never causes a hazard.
- Hazard with `HAZARD_FWD_EN` off: any match in Exec, Mem or WB. The register file writes at the end of WB, so a WB producer is still stale at decode read time.
- Hazard with `HAZARD_FWD_EN` on: only a match against an Exec entry with is_load=1 (load-use).
- Hazard response: `stall_if`=`stall_dec`=`bubble_exec`=1, and only while `dec_valid` is high.
- Redirect response:
  - `flush_dec`=`flush_exec`=1 and all stall outputs are 0. Redirect has priority over a hazard in the same cycle.
  - At the next edge the scoreboard Exec entry is cleared.
  - The Mem entry (the branch itself) advances normally.
- Forward selects, priority youngest first: 01 = Exec ALU result, 10 = Mem-stage writeback value, 11 = WB writeback value, 00 = register file.
  - A load in Exec never yields 01; the stall covers that case.
- FSM:
  - RUN → STALL when a hazard is present.
  - STALL → RUN when the hazard clears.
  - Any state → FLUSH on `redirect`.
  - FLUSH → RUN after one cycle. In FLUSH, hazard detection is masked because Dec holds a squashed slot.
  - A redirect arriving in STALL goes directly to FLUSH and drops the stall.

## Timing
- Every output is combinational from the current inputs and the registered scoreboard/FSM, so it takes effect at the upcoming edge.
- Stall length without forwarding:
  - 3 cycles when the producer is directly ahead in Exec.
  - 2 cycles when it is in Mem.
  - 1 cycle when it is in WB.
- Stall length with forwarding: 1 cycle for load-use, 0 otherwise.
- Redirect penalty: exactly 3 squashed slots (IF, Dec, Exec at the redirect cycle). `flush_*` is high for one cycle per `redirect` cycle.
- Reset:
  - Scoreboard all invalid, `state`=RUN.
  - While `rstn` is low, every output is forced to 0 (including `fwd_*_sel`=00).
  - A reset asserted mid-stall or mid-flush abandons it; the first cycle after release is RUN with no hazard.

## Configuration
- `HAZARD_FWD_EN` defined:
  - Forward-select outputs exist.
  - Only load-use stalls.
- `HAZARD_FWD_EN` undefined:
  - Forward ports are omitted.
  - All RAW dependencies on Exec, Mem or WB stall until the producer has retired.

## Structure
- Shared package `pipeline_pkg`:
  - FSM state encoding.
  - Forward-select constants (`FWD_RF`, `FWD_EXEC`, `FWD_MEM`, `FWD_WB`).
  - Scoreboard entry struct.
  - Register index width 5.
- One natural sub-module, `hazard_match`: combinational compare of one source against the three scoreboard entries. It returns hit-per-stage and the load flag, and is instantiated twice (rs1, rs2).

## Test plan
- No forwarding, back-to-back dependency: `addi x5,x0,1` then `add x6,x5,x5` → stall/bubble high for 3 cycles, `state`=STALL, x6 reads 2.
- x0 destination: `addi x0,x0,7` then `add x1,x0,x0` → no stall in either configuration.
- Forwarding, load-use: `lw x7,0(x2)` then `add x8,x7,x1` → 1-cycle stall, then `fwd_a_sel`=10. A non-dependent following instruction has 0 stalls.
- Forwarding priority: x9 written in both Exec and Mem, then read → `fwd_a_sel`=01 (youngest). With the producer only in WB → 11.
- Redirect during stall: hazard active and `redirect`=1 in the same cycle → `flush_dec`=`flush_exec`=1, `stall_if`=0, `state`=FLUSH, then RUN the next cycle. Scoreboard Exec entry is invalid.
- Reset mid-stall: drop `rstn` during the second stall cycle → all outputs 0 immediately. After release, `state`=RUN and the scoreboard is empty.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the 5-stage RV32 pipeline hazard/flush scheduler.
// Holds the FSM state encoding, forward-select codes, the scoreboard entry
// layout and the small compare/priority helpers. Forwarding is controlled by
// the HAZARD_FWD_EN macro.
package pipeline_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXEC = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b11;

  // One in-flight writer as seen by the scheduler.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wen;
    logic             is_load;
  } sb_entry_t;

  // True when entry e produces the register that source src actually reads.
  // x0 is never a producer.
  function automatic logic sb_match(sb_entry_t e, logic [REG_W-1:0] src, logic used);
    return e.valid && e.wen && (e.rd != '0) && (e.rd == src) && used;
  endfunction

  // Youngest producer wins; a load still in Exec has no result to bypass,
  // so it falls through to older producers (the load-use stall covers it).
  function automatic logic [1:0] fwd_pick(logic hit_exec, logic load_hit,
                                          logic hit_mem, logic hit_wb);
    if (hit_exec && !load_hit) return FWD_EXEC;
    if (hit_mem)               return FWD_MEM;
    if (hit_wb)                return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-side bundle between the pipeline datapath (master) and the hazard
// scheduler (slave). Forward selects exist only with HAZARD_FWD_EN.
//
// Timing contract: the dec_* fields and redirect describe the current cycle;
// every control returned (stall, bubble, flush, forward select) is
// combinational from them and acts at the next rising clk edge. There is no
// ready/valid back-pressure beyond stall_if/stall_dec.
interface pipeline_hazard_ctrl_if;
  import pipeline_pkg::*;

  logic             dec_valid;
  logic [REG_W-1:0] dec_rs1;
  logic [REG_W-1:0] dec_rs2;
  logic             dec_rs1_used;
  logic             dec_rs2_used;
  logic [REG_W-1:0] dec_rd;
  logic             dec_wen;
  logic             dec_is_load;
  logic             redirect;

  logic             stall_if;
  logic             stall_dec;
  logic             bubble_exec;
  logic             flush_dec;
  logic             flush_exec;
`ifdef HAZARD_FWD_EN
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
`endif

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_rd, dec_wen, dec_is_load, redirect,
    input  stall_if, stall_dec, bubble_exec, flush_dec, flush_exec
`ifdef HAZARD_FWD_EN
    , fwd_a_sel, fwd_b_sel
`endif
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
           dec_rd, dec_wen, dec_is_load, redirect,
    output stall_if, stall_dec, bubble_exec, flush_dec, flush_exec
`ifdef HAZARD_FWD_EN
    , fwd_a_sel, fwd_b_sel
`endif
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// Compares one decode source register against the Exec/Mem/WB scoreboard
// entries. Reports a hit per stage plus whether the Exec hit is a load.
module hazard_match
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  sb_entry_t        sb_exec,
  input  sb_entry_t        sb_mem,
  input  sb_entry_t        sb_wb,
  output logic             hit_exec,
  output logic             hit_mem,
  output logic             hit_wb,
  output logic             load_hit
);

  // Only the Exec stage's load flag matters: older loads have their data.
  logic unused_is_load;

  assign hit_exec       = sb_match(sb_exec, src, used);
  assign hit_mem        = sb_match(sb_mem, src, used);
  assign hit_wb         = sb_match(sb_wb, src, used);
  assign load_hit       = hit_exec && sb_exec.is_load;
  assign unused_is_load = sb_mem.is_load ^ sb_wb.is_load;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and flush scheduler for the IF/Dec/Exec/Mem/WB pipeline.
// Tracks in-flight writers, stalls Dec on RAW hazards, squashes wrong-path
// slots on redirect. Build option HAZARD_FWD_EN: stall only on load-use and
// drive operand bypass selects.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  pipeline_hazard_ctrl_if.slave  bus,
  output logic [1:0]             state
);

  hz_state_e state_q, state_d;
  sb_entry_t sb_exec, sb_mem, sb_wb;

  logic a_exec, a_mem, a_wb, a_load;
  logic b_exec, b_mem, b_wb, b_load;
  logic hit_raw;
  logic hazard;
  logic stall_eff;

  hazard_match u_match_a (
    .src      (bus.dec_rs1),
    .used     (bus.dec_rs1_used),
    .sb_exec  (sb_exec),
    .sb_mem   (sb_mem),
    .sb_wb    (sb_wb),
    .hit_exec (a_exec),
    .hit_mem  (a_mem),
    .hit_wb   (a_wb),
    .load_hit (a_load)
  );

  hazard_match u_match_b (
    .src      (bus.dec_rs2),
    .used     (bus.dec_rs2_used),
    .sb_exec  (sb_exec),
    .sb_mem   (sb_mem),
    .sb_wb    (sb_wb),
    .hit_exec (b_exec),
    .hit_mem  (b_mem),
    .hit_wb   (b_wb),
    .load_hit (b_load)
  );

`ifdef HAZARD_FWD_EN
  // Bypassing covers everything except a load whose data is not back yet.
  assign hit_raw = a_load | b_load;
`else
  // Register file writes at the end of WB, so any in-flight writer is stale.
  logic unused_load;
  assign unused_load = a_load ^ b_load;
  assign hit_raw = a_exec | a_mem | a_wb | b_exec | b_mem | b_wb;
`endif

  // Dec holds a squashed slot in FLUSH, so its sources mean nothing there.
  assign hazard    = hit_raw && bus.dec_valid && (state_q != ST_FLUSH);
  assign stall_eff = hazard && !bus.redirect;
  assign state     = state_q;

  // Scoreboard shift: WB<-Mem<-Exec<-Dec, Exec empty on bubble or flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb_exec <= '0;
      sb_mem  <= '0;
      sb_wb   <= '0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_exec;
      if (bus.dec_valid && !stall_eff && !bus.redirect) begin
        sb_exec.valid   <= 1'b1;
        sb_exec.rd      <= bus.dec_rd;
        sb_exec.wen     <= bus.dec_wen;
        sb_exec.is_load <= bus.dec_is_load;
      end else begin
        sb_exec <= '0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state and pipeline controls; everything is held at 0 in reset.
  always_comb begin
    state_d         = state_q;
    bus.stall_if    = 1'b0;
    bus.stall_dec   = 1'b0;
    bus.bubble_exec = 1'b0;
    bus.flush_dec   = 1'b0;
    bus.flush_exec  = 1'b0;
`ifdef HAZARD_FWD_EN
    bus.fwd_a_sel   = FWD_RF;
    bus.fwd_b_sel   = FWD_RF;
`endif
    if (bus.redirect) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   if (hazard) state_d = ST_STALL;
        ST_STALL: if (!hazard) state_d = ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
    if (rstn) begin
      bus.stall_if    = stall_eff;
      bus.stall_dec   = stall_eff;
      bus.bubble_exec = stall_eff;
      bus.flush_dec   = bus.redirect;
      bus.flush_exec  = bus.redirect;
`ifdef HAZARD_FWD_EN
      bus.fwd_a_sel   = fwd_pick(a_exec, a_load, a_mem, a_wb);
      bus.fwd_b_sel   = fwd_pick(b_exec, b_load, b_mem, b_wb);
`endif
    end
  end

endmodule
